prty_chk_strip: RTL and testbench
=================================

Name: prty_chk_strip

Overview:
- Parametrised parity checker and stripper for cell-parity-protected buses. Input word is data plus one parity bit per CELL_WTH-bit cell, parity bits in the MSBs.
- Recomputes cell parity, flags mismatches per cell, strips the parity, and forwards data through one registered valid/ready stage.
- Keeps a saturating error-word counter and a sticky error flag for CSR readout.
- Sits at the receive side of any path whose transmit side appends cell parity (FIFO/RAM outputs, inter-module buses).

Parameters:
- DATA_WTH, 279, payload width in bits.
- CELL_WTH, 32, bits covered by each parity bit.
- PRTY_WTH, ceil(DATA_WTH/CELL_WTH) (derived, not overridden), number of parity bits.
- ODD_PRTY, 0, 0 = even parity (parity bit = XOR of cell); 1 = odd parity (parity bit = ~XOR of cell).
- CNT_WTH, 16, error counter width.

Ports:
- clk_sys  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_vld  input  1  input word valid.
- in_data  input  DATA_WTH+PRTY_WTH  {parity[PRTY_WTH-1:0], data[DATA_WTH-1:0]}.
- in_rdy  output  1  block can accept a word this cycle.
- out_vld  output  1  output word valid.
- out_data  output  DATA_WTH  stripped payload.
- out_rdy  input  1  downstream accepts the word.
- out_err  output  1  output word has at least one bad cell; aligned with out_data.
- err_cell  output  PRTY_WTH  per-cell mismatch bits; aligned with out_data.
- err_cnt  output  CNT_WTH  count of errored words handed off; saturating.
- err_sticky  output  1  set on the first errored handoff; held until cleared.
- err_clr  input  1  synchronous clear of err_cnt and err_sticky.

Behaviour:
- Reset: out_vld, out_data, out_err, err_cell, err_cnt and err_sticky all 0. Reset applies on any cycle, including while a word is held, and discards that word.
- Cell mapping:
  - Cell i (i < PRTY_WTH-1) covers data[i*CELL_WTH+CELL_WTH-1 : i*CELL_WTH].
  - The last cell covers data[DATA_WTH-1 : (PRTY_WTH-1)*CELL_WTH] and may be narrower than CELL_WTH.
  - Parity bit i is in_data[DATA_WTH+i].
- Check: err_cell[i] = (XOR of cell i) ^ ODD_PRTY ^ parity bit i. out_err = OR of err_cell. Computed combinationally at the input, registered together with the data.
- Handshake:
  - in_rdy = ~out_vld | out_rdy (combinational, no bubble).
  - Load on in_vld & in_rdy. Latency 1 cycle.
  - Back-to-back words pass at full rate when out_rdy is held high.
  - While out_vld & ~out_rdy, out_data, out_err and err_cell hold stable.
  - out_vld drops after a handoff that has no new input in the same cycle.
- Counter and sticky flag, evaluated on errored handoff (out_vld & out_rdy & out_err):
  - err_cnt increments by 1 per errored word, not per bad cell, and saturates at 2^CNT_WTH-1 (no wrap).
  - err_sticky sets to 1.
  - A held, un-accepted word is counted once, at its handoff.
- err_clr:
  - Clears err_cnt to 0 and err_sticky to 0 on the next edge.
  - If err_clr coincides with an errored handoff, the new event wins: err_cnt = 1 and err_sticky = 1.
  - err_clr does not affect the data path.
- in_vld with in_rdy = 0 is not consumed; the upstream source holds the word.

Test Plan (DATA_WTH=40, CELL_WTH=16 → PRTY_WTH=3, cells [15:0],[31:16],[39:32]; ODD_PRTY=0 unless stated):
- Clean word: in_data data=0x00_0000_0001, parity=3'b001, out_rdy=1 → next cycle out_vld=1, out_data=0x0000000001, err_cell=0, out_err=0, err_cnt=0.
- Single-cell error: data=0x02_0000_0000, parity=3'b000 → err_cell=3'b100, out_err=1; after handoff err_cnt=1, err_sticky=1.
- Backpressure: errored word, out_rdy=0 for 3 cycles then 1 → in_rdy=0 during the hold, out_data/err_cell stable, err_cnt increments exactly once at handoff.
- Saturation: CNT_WTH=2, five errored words accepted back-to-back → err_cnt goes 1,2,3,3,3.
- Clear: err_clr with no handoff → err_cnt=0, err_sticky=0; err_clr in the same cycle as an errored handoff → err_cnt=1, err_sticky=1.
- Odd parity and reset: ODD_PRTY=1, data=0, parity=3'b111 → out_err=0; parity=3'b000 → err_cell=3'b111. Then assert rst while out_vld=1 → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/prty_chk_strip.sv
// prty_chk_strip: receive-side cell-parity checker and stripper.
// The input word carries one parity bit per CELL_WTH-bit payload cell in its
// MSBs. Parity is recomputed per cell and mismatches are flagged. The parity
// is then stripped and the payload is forwarded through one registered
// valid/ready stage. A saturating counter and a sticky flag record errored
// words at the moment they are handed downstream.
module prty_chk_strip #(
  parameter int DATA_WTH = 279,
  parameter int CELL_WTH = 32,
  parameter int ODD_PRTY = 0,
  parameter int CNT_WTH  = 16,
  // Derived from the payload and cell widths; not meant to be overridden.
  localparam int PRTY_WTH = (DATA_WTH + CELL_WTH - 1) / CELL_WTH
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic [DATA_WTH+PRTY_WTH-1:0] in_data,
  output logic                         in_rdy,
  output logic                         out_vld,
  output logic [DATA_WTH-1:0]          out_data,
  input  logic                         out_rdy,
  output logic                         out_err,
  output logic [PRTY_WTH-1:0]          err_cell,
  output logic [CNT_WTH-1:0]           err_cnt,
  output logic                         err_sticky,
  input  logic                         err_clr
);

  localparam logic               ODD_BIT = (ODD_PRTY != 0);
  localparam logic [CNT_WTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WTH-1:0] CNT_ONE = {{(CNT_WTH-1){1'b0}}, 1'b1};

  // Input word split into payload and per-cell parity.
  logic [DATA_WTH-1:0] in_payload;
  logic [PRTY_WTH-1:0] in_prty;
  logic [PRTY_WTH-1:0] cell_err;
  logic                word_err;

  assign in_payload = in_data[DATA_WTH-1:0];
  assign in_prty    = in_data[DATA_WTH +: PRTY_WTH];

  // Per-cell parity check. The last cell takes whatever payload bits remain,
  // so it can be narrower than CELL_WTH.
  generate
    for (genvar gi = 0; gi < PRTY_WTH; gi++) begin : g_cell
      localparam int LO = gi * CELL_WTH;
      localparam int HI = (gi == PRTY_WTH - 1) ? (DATA_WTH - 1) : (LO + CELL_WTH - 1);
      assign cell_err[gi] = (^in_payload[HI:LO]) ^ ODD_BIT ^ in_prty[gi];
    end
  endgenerate

  assign word_err = |cell_err;

  // Output stage registers.
  logic                out_vld_reg;
  logic [DATA_WTH-1:0] out_data_reg;
  logic                out_err_reg;
  logic [PRTY_WTH-1:0] err_cell_reg;

  // Error statistics registers and their next-state values.
  logic [CNT_WTH-1:0]  err_cnt_reg;
  logic [CNT_WTH-1:0]  err_cnt_next;
  logic                err_sticky_reg;
  logic                err_sticky_next;

  logic                load;
  logic                handoff;
  logic                handoff_err;

  // The stage accepts whenever it is empty or is emptying this same cycle,
  // so streaming with out_rdy held high runs at full rate with no bubble.
  assign in_rdy      = ~out_vld_reg | out_rdy;
  assign load        = in_vld & in_rdy;
  assign handoff     = out_vld_reg & out_rdy;
  assign handoff_err = handoff & out_err_reg;

  // Output stage: capture payload and check result together; hold while stalled.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
      err_cell_reg <= '0;
    end else if (load) begin
      out_vld_reg  <= 1'b1;
      out_data_reg <= in_payload;
      out_err_reg  <= word_err;
      err_cell_reg <= cell_err;
    end else if (handoff) begin
      out_vld_reg  <= 1'b0;
    end
  end

  // Statistics next state: an errored handoff takes priority over a clear,
  // so a clear in that cycle leaves exactly this one event recorded.
  always_comb begin
    err_cnt_next    = err_cnt_reg;
    err_sticky_next = err_sticky_reg;
    if (handoff_err) begin
      err_sticky_next = 1'b1;
      if (err_clr) begin
        err_cnt_next = CNT_ONE;
      end else if (err_cnt_reg != CNT_MAX) begin
        err_cnt_next = err_cnt_reg + CNT_ONE;
      end
    end else if (err_clr) begin
      err_cnt_next    = '0;
      err_sticky_next = 1'b0;
    end
  end

  // Statistics registers. Counting happens only at handoff, so a word held
  // under backpressure is counted once.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      err_cnt_reg    <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      err_cnt_reg    <= err_cnt_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign out_vld    = out_vld_reg;
  assign out_data   = out_data_reg;
  assign out_err    = out_err_reg;
  assign err_cell   = err_cell_reg;
  assign err_cnt    = err_cnt_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_prty_chk_strip.sv
// Bench for prty_chk_strip: three instances share one stimulus stream
// (even parity / 16-bit counter, even parity / 2-bit counter, odd parity).
// Accepted words are queued with their payload and parity. The expected
// per-cell result is recomputed from fixed cell boundaries when a word leaves.
module tb_prty_chk_strip;

  localparam int DW = 40;
  localparam int CW = 16;
  localparam int PW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } item_t;

  logic           clk_sys = 1'b0;
  logic           rst;
  logic           in_vld;
  logic [DW+PW-1:0] in_data;
  logic           out_rdy;
  logic           err_clr;

  logic           a_in_rdy, a_out_vld, a_out_err, a_err_sticky;
  logic [DW-1:0]  a_out_data;
  logic [PW-1:0]  a_err_cell;
  logic [15:0]    a_err_cnt;

  logic           s_in_rdy, s_out_vld, s_out_err, s_err_sticky;
  logic [DW-1:0]  s_out_data;
  logic [PW-1:0]  s_err_cell;
  logic [1:0]     s_err_cnt;

  logic           o_in_rdy, o_out_vld, o_out_err, o_err_sticky;
  logic [DW-1:0]  o_out_data;
  logic [PW-1:0]  o_err_cell;
  logic [15:0]    o_err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  item_t q[$];
  bit    mvld = 1'b0;
  int    cnt_a = 0, cnt_s = 0, cnt_o = 0;
  bit    stk_a = 1'b0, stk_s = 1'b0, stk_o = 1'b0;
  int    exp_sat [5];

  always #5 clk_sys = ~clk_sys;

  prty_chk_strip #(.DATA_WTH(DW), .CELL_WTH(CW), .ODD_PRTY(0), .CNT_WTH(16)) u_even (
    .clk_sys(clk_sys), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(a_in_rdy),
    .out_vld(a_out_vld), .out_data(a_out_data), .out_rdy(out_rdy), .out_err(a_out_err),
    .err_cell(a_err_cell), .err_cnt(a_err_cnt), .err_sticky(a_err_sticky), .err_clr(err_clr));

  prty_chk_strip #(.DATA_WTH(DW), .CELL_WTH(CW), .ODD_PRTY(0), .CNT_WTH(2)) u_sat (
    .clk_sys(clk_sys), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(s_in_rdy),
    .out_vld(s_out_vld), .out_data(s_out_data), .out_rdy(out_rdy), .out_err(s_out_err),
    .err_cell(s_err_cell), .err_cnt(s_err_cnt), .err_sticky(s_err_sticky), .err_clr(err_clr));

  prty_chk_strip #(.DATA_WTH(DW), .CELL_WTH(CW), .ODD_PRTY(1), .CNT_WTH(16)) u_odd (
    .clk_sys(clk_sys), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(o_in_rdy),
    .out_vld(o_out_vld), .out_data(o_out_data), .out_rdy(out_rdy), .out_err(o_out_err),
    .err_cell(o_err_cell), .err_cnt(o_err_cnt), .err_sticky(o_err_sticky), .err_clr(err_clr));

  // Cells are [15:0], [31:16] and the narrow [39:32].
  function automatic logic [PW-1:0] cells(logic [DW-1:0] d, logic [PW-1:0] p, bit odd);
    logic [PW-1:0] c;
    c[0] = (^d[15:0])  ^ odd ^ p[0];
    c[1] = (^d[31:16]) ^ odd ^ p[1];
    c[2] = (^d[39:32]) ^ odd ^ p[2];
    return c;
  endfunction

  function automatic int next_cnt(int cnt, bit ev, bit clr, int maxv);
    if (ev) return clr ? 1 : ((cnt == maxv) ? cnt : cnt + 1);
    if (clr) return 0;
    return cnt;
  endfunction

  function automatic bit next_stk(bit stk, bit ev, bit clr);
    if (ev) return 1'b1;
    if (clr) return 1'b0;
    return stk;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: mid-cycle checks of the output stage against the
  // scoreboard, model update, then post-edge checks of the statistics.
  task automatic cyc();
    bit hnd, acc, ev_a, ev_s, ev_o;
    item_t it;
    #4;
    hnd = mvld && out_rdy;
    acc = in_vld && (!mvld || out_rdy);
    chk("in_rdy", a_in_rdy, !mvld || out_rdy);
    chk("out_vld_even", a_out_vld, mvld);
    chk("out_vld_sat", s_out_vld, mvld);
    chk("out_vld_odd", o_out_vld, mvld);
    if (mvld) begin
      it = q[0];
      chk("out_data_even", a_out_data, it.d);
      chk("out_data_odd", o_out_data, it.d);
      chk("err_cell_even", a_err_cell, cells(it.d, it.p, 1'b0));
      chk("out_err_even", a_out_err, |cells(it.d, it.p, 1'b0));
      chk("err_cell_odd", o_err_cell, cells(it.d, it.p, 1'b1));
      chk("out_err_odd", o_out_err, |cells(it.d, it.p, 1'b1));
    end
    if (hnd) $display("handoff data=%010h prty=%03b clr=%0b", q[0].d, q[0].p, err_clr);
    if (acc) $display("accept  data=%010h prty=%03b", in_data[DW-1:0], in_data[DW+PW-1:DW]);
    if (rst) begin
      q.delete();
      mvld = 1'b0;
      cnt_a = 0; cnt_s = 0; cnt_o = 0;
      stk_a = 1'b0; stk_s = 1'b0; stk_o = 1'b0;
    end else begin
      ev_a = 1'b0; ev_s = 1'b0; ev_o = 1'b0;
      if (hnd) begin
        it = q.pop_front();
        ev_a = |cells(it.d, it.p, 1'b0);
        ev_s = ev_a;
        ev_o = |cells(it.d, it.p, 1'b1);
      end
      cnt_a = next_cnt(cnt_a, ev_a, err_clr, 65535);
      cnt_s = next_cnt(cnt_s, ev_s, err_clr, 3);
      cnt_o = next_cnt(cnt_o, ev_o, err_clr, 65535);
      stk_a = next_stk(stk_a, ev_a, err_clr);
      stk_s = next_stk(stk_s, ev_s, err_clr);
      stk_o = next_stk(stk_o, ev_o, err_clr);
      if (acc) q.push_back(item_t'{d: in_data[DW-1:0], p: in_data[DW+PW-1:DW]});
      mvld = acc || (mvld && !out_rdy);
    end
    @(posedge clk_sys);
    #1;
    chk("err_cnt_even", a_err_cnt, cnt_a);
    chk("err_cnt_sat", s_err_cnt, cnt_s);
    chk("err_cnt_odd", o_err_cnt, cnt_o);
    chk("sticky_even", a_err_sticky, stk_a);
    chk("sticky_sat", s_err_sticky, stk_s);
    chk("sticky_odd", o_err_sticky, stk_o);
  endtask

  initial begin
    exp_sat = '{1, 2, 3, 3, 3};
    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1; err_clr = 1'b0;
    @(posedge clk_sys); #1;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state.
    chk("rst_out_vld", a_out_vld, 1'b0);
    chk("rst_out_data", a_out_data, 40'h0);
    chk("rst_out_err", a_out_err, 1'b0);
    chk("rst_err_cell", a_err_cell, 3'b000);
    chk("rst_err_cnt", a_err_cnt, 16'h0);
    chk("rst_sticky", a_err_sticky, 1'b0);

    // Clean word.
    in_vld = 1'b1; in_data = {3'b001, 40'h00_0000_0001};
    cyc();
    in_vld = 1'b0;
    chk("clean_vld", a_out_vld, 1'b1);
    chk("clean_data", a_out_data, 40'h00_0000_0001);
    chk("clean_cell", a_err_cell, 3'b000);
    chk("clean_err", a_out_err, 1'b0);
    chk("clean_cnt", a_err_cnt, 16'h0);
    cyc();

    // Single bad cell in the narrow top cell.
    in_vld = 1'b1; in_data = {3'b000, 40'h02_0000_0000};
    cyc();
    in_vld = 1'b0;
    chk("single_cell", a_err_cell, 3'b100);
    chk("single_err", a_out_err, 1'b1);
    cyc();
    chk("single_cnt", a_err_cnt, 16'h1);
    chk("single_sticky", a_err_sticky, 1'b1);

    // Backpressure: errored word held for three cycles, counted once.
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = {3'b000, 40'h00_0001_0000};
    cyc();
    in_data = {3'b000, 40'h00_0000_0005};
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_rdy", a_in_rdy, 1'b0);
      chk("bp_data", a_out_data, 40'h00_0001_0000);
      chk("bp_cell", a_err_cell, 3'b010);
      chk("bp_cnt", a_err_cnt, 16'h1);
      cyc();
    end
    out_rdy = 1'b1;
    cyc();
    in_vld = 1'b0;
    chk("bp_cnt_after", a_err_cnt, 16'h2);
    chk("bp_next_data", a_out_data, 40'h00_0000_0005);
    cyc();
    chk("bp_drained", a_out_vld, 1'b0);
    chk("bp_cnt_final", a_err_cnt, 16'h2);

    // Clear with no handoff.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_cnt", a_err_cnt, 16'h0);
    chk("clr_sticky", a_err_sticky, 1'b0);
    chk("clr_cnt_sat", s_err_cnt, 2'd0);

    // Saturation of the 2-bit counter: five errored words back to back.
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_data = {3'b000, 40'h1 << i};
      cyc();
      if (i > 0) chk("sat_cnt", s_err_cnt, exp_sat[i-1]);
    end
    in_vld = 1'b0;
    cyc();
    chk("sat_cnt_last", s_err_cnt, exp_sat[4]);
    chk("sat_cnt_wide", a_err_cnt, 16'd5);

    // Clear coinciding with an errored handoff: the event wins.
    in_vld = 1'b1; in_data = {3'b010, 40'h00_0000_0000};
    cyc();
    in_vld = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_hit_cnt", a_err_cnt, 16'h1);
    chk("clr_hit_sticky", a_err_sticky, 1'b1);
    chk("clr_hit_cnt_sat", s_err_cnt, 2'd1);

    // Odd parity, then reset while a word is held.
    in_vld = 1'b1; in_data = {3'b111, 40'h0};
    cyc();
    chk("odd_clean_err", o_out_err, 1'b0);
    chk("odd_clean_cell", o_err_cell, 3'b000);
    in_data = {3'b000, 40'h0};
    cyc();
    in_vld = 1'b0;
    chk("odd_bad_cell", o_err_cell, 3'b111);
    chk("odd_bad_err", o_out_err, 1'b1);
    out_rdy = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_held_vld", o_out_vld, 1'b0);
    chk("rst_held_data", o_out_data, 40'h0);
    chk("rst_held_cell", o_err_cell, 3'b000);
    chk("rst_held_err", o_out_err, 1'b0);
    chk("rst_held_cnt", o_err_cnt, 16'h0);
    chk("rst_held_sticky", o_err_sticky, 1'b0);
    chk("rst_held_cnt_even", a_err_cnt, 16'h0);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      in_data = {$urandom_range(0, 7), $urandom_range(0, 255), $urandom()};
      cyc();
    end
    in_vld = 1'b0; out_rdy = 1'b1; err_clr = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
